toy_mem_arbiter: RTL

//  Shares one single-ported memory between the RISC_TOY fetch port (IREQ/IADDR/INSTR) and MEM-stage data port (DREQ/DRW/DADDR).

---
 rtl/toy_mem_pkg.sv | 16 +
 rtl/toy_mem_arbiter_if.sv | 33 +++
 rtl/toy_fetch_buf.sv | 41 ++++
 rtl/toy_mem_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/toy_mem_pkg.sv
// Shared types and defaults for the RISC_TOY memory arbiter.
package toy_mem_pkg;

    localparam int unsigned AW_DEF          = 30;
    localparam int unsigned DW_DEF          = 32;
    localparam int unsigned MAX_DSTREAK_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_IBUSY = 3'd1,
        ST_DBUSY = 3'd2,
        ST_IRESP = 3'd3,
        ST_DRESP = 3'd4
    } state_e;

endpackage

// File: rtl/toy_mem_arbiter_if.sv
// Core fetch/data ports and memory port of the arbiter, grouped as one bundle.
// slave: arbiter view; master: core + memory environment view.
interface toy_mem_arbiter_if #(
    parameter int unsigned AW = 30,
    parameter int unsigned DW = 32
);
    logic          IREQ;
    logic [AW-1:0] IADDR;
    logic          IVALID;
    logic [DW-1:0] INSTR;
    logic          DREQ;
    logic          DRW;
    logic [AW-1:0] DADDR;
    logic [DW-1:0] DWDATA;
    logic          DVALID;
    logic [DW-1:0] DRDATA;
    logic          MREQ;
    logic          MRW;
    logic [AW-1:0] MADDR;
    logic [DW-1:0] MWDATA;
    logic [DW-1:0] MRDATA;
    logic          MRDY;

    modport slave (
        input  IREQ, IADDR, DREQ, DRW, DADDR, DWDATA, MRDATA, MRDY,
        output IVALID, INSTR, DVALID, DRDATA, MREQ, MRW, MADDR, MWDATA
    );

    modport master (
        output IREQ, IADDR, DREQ, DRW, DADDR, DWDATA, MRDATA, MRDY,
        input  IVALID, INSTR, DVALID, DRDATA, MREQ, MRW, MADDR, MWDATA
    );
endinterface

// File: rtl/toy_fetch_buf.sv
// One-entry fetch buffer {valid, addr, instr}; only instantiated when FETCH_BUF_EN is defined.
module toy_fetch_buf #(
    parameter int unsigned AW = 30,
    parameter int unsigned DW = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] lookup_addr_i,
    output logic          hit_o,
    output logic [DW-1:0] instr_o,
    input  logic          fill_i,
    input  logic [AW-1:0] fill_addr_i,
    input  logic [DW-1:0] fill_instr_i,
    input  logic          inval_i,
    input  logic [AW-1:0] inval_addr_i
);
    logic          valid_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] instr_q;

    // Hit when the stored entry is valid and matches the fetch address.
    always_comb begin
        hit_o   = valid_q && (addr_q == lookup_addr_i);
        instr_o = instr_q;
    end

    // Fill on completed fetch; drop the entry on a write to the same address.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            addr_q  <= fill_addr_i;
            instr_q <= fill_instr_i;
        end else if (inval_i && (inval_addr_i == addr_q)) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/toy_mem_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch and data ports.
// Data has priority; a streak counter forces a fetch after MAX_DSTREAK data grants.
// Optional feature: define FETCH_BUF_EN to add a one-entry fetch buffer.
module toy_mem_arbiter
    import toy_mem_pkg::*;
#(
    parameter int unsigned AW          = AW_DEF,
    parameter int unsigned DW          = DW_DEF,
    parameter int unsigned MAX_DSTREAK = MAX_DSTREAK_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    toy_mem_arbiter_if.slave bus
);
    localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    state_e        state_q, state_d;
    logic          mreq_q, mreq_d;
    logic          mrw_q, mrw_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [DW-1:0] mwdata_q, mwdata_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [DW-1:0] drdata_q, drdata_d;
    logic [SW-1:0] streak_q, streak_d;

    logic          grant_i;
    logic          grant_d;
    logic          fb_hit;
    logic [DW-1:0] fb_instr;

`ifdef FETCH_BUF_EN
    logic fb_fill;
    logic fb_inval;

    // Fill on any completed fetch; invalidate on a completing write.
    always_comb begin
        fb_fill  = (state_q == ST_IBUSY) && bus.MRDY;
        fb_inval = (state_q == ST_DBUSY) && bus.MRDY && mrw_q;
    end

    toy_fetch_buf #(
        .AW (AW),
        .DW (DW)
    ) u_fetch_buf (
        .CLK           (CLK),
        .RST           (RST),
        .lookup_addr_i (bus.IADDR),
        .hit_o         (fb_hit),
        .instr_o       (fb_instr),
        .fill_i        (fb_fill),
        .fill_addr_i   (maddr_q),
        .fill_instr_i  (bus.MRDATA),
        .inval_i       (fb_inval),
        .inval_addr_i  (maddr_q)
    );
`else
    assign fb_hit   = 1'b0;
    assign fb_instr = '0;
`endif

    // Next-state, memory command and streak update.
    always_comb begin
        state_d  = state_q;
        mreq_d   = mreq_q;
        mrw_d    = mrw_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        instr_d  = instr_q;
        drdata_d = drdata_q;
        streak_d = streak_q;
        grant_i  = 1'b0;
        grant_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_i = bus.IREQ && (!bus.DREQ || (streak_q == STREAK_MAX));
                grant_d = bus.DREQ && !grant_i;
                if (grant_d) begin
                    state_d  = ST_DBUSY;
                    mreq_d   = 1'b1;
                    mrw_d    = bus.DRW;
                    maddr_d  = bus.DADDR;
                    mwdata_d = bus.DWDATA;
                    if (!bus.IREQ) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (grant_i) begin
                    streak_d = '0;
                    if (fb_hit) begin
                        state_d = ST_IRESP;
                        instr_d = fb_instr;
                    end else begin
                        state_d = ST_IBUSY;
                        mreq_d  = 1'b1;
                        mrw_d   = 1'b0;
                        maddr_d = bus.IADDR;
                    end
                end
            end
            ST_IBUSY: begin
                if (bus.MRDY) begin
                    mreq_d  = 1'b0;
                    instr_d = bus.MRDATA;
                    state_d = ST_IRESP;
                end
            end
            ST_DBUSY: begin
                if (bus.MRDY) begin
                    mreq_d = 1'b0;
                    if (!mrw_q) begin
                        drdata_d = bus.MRDATA;
                    end
                    state_d = ST_DRESP;
                end
            end
            ST_IRESP, ST_DRESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                mreq_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            mreq_q   <= 1'b0;
            mrw_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            instr_q  <= '0;
            drdata_q <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            mreq_q   <= mreq_d;
            mrw_q    <= mrw_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            instr_q  <= instr_d;
            drdata_q <= drdata_d;
            streak_q <= streak_d;
        end
    end

    // Outputs: VALID pulses decode directly from the response states.
    always_comb begin
        bus.MREQ   = mreq_q;
        bus.MRW    = mrw_q;
        bus.MADDR  = maddr_q;
        bus.MWDATA = mwdata_q;
        bus.INSTR  = instr_q;
        bus.DRDATA = drdata_q;
        bus.IVALID = (state_q == ST_IRESP);
        bus.DVALID = (state_q == ST_DRESP);
    end
endmodule
